// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the RV32M execution unit: widths, funct3 codes, FSM states.
package ex_muldiv_unit_pkg;

  localparam int MD_XLEN  = 32;
  localparam int MD_CNT_W = 6;

  localparam logic [1:0] M_CLASS = 2'b01;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic is_m_op(input logic [4:0] op);
    return op[4:3] == M_CLASS;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage link between the ID/EX register and the M unit; the unit is the slave side.
interface ex_muldiv_unit_if;

  logic [4:0]                               IN_ALU_OP;
  logic [ex_muldiv_unit_pkg::MD_XLEN-1:0]   IN_DATA1;
  logic [ex_muldiv_unit_pkg::MD_XLEN-1:0]   IN_DATA2;
  logic                                     IN_FLUSH;
  logic [ex_muldiv_unit_pkg::MD_XLEN-1:0]   OUT_RESULT;
  logic                                     OUT_DONE;
  logic                                     OUT_BUSYWAIT;

  modport master (
    output IN_ALU_OP, IN_DATA1, IN_DATA2, IN_FLUSH,
    input  OUT_RESULT, OUT_DONE, OUT_BUSYWAIT
  );

  modport slave (
    input  IN_ALU_OP, IN_DATA1, IN_DATA2, IN_FLUSH,
    output OUT_RESULT, OUT_DONE, OUT_BUSYWAIT
  );

endinterface

// File: rtl/ex_muldiv_unit_div_core.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per step.
// start loads operands; last flags the XLEN-th step.
module div_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    partial;
  logic [XLEN-1:0]  diff;
  logic             take;

  // The shifted partial remainder needs one extra bit before the trial subtract.
  always_comb begin
    partial = {remainder, quotient[XLEN-1]};
    take    = (partial >= {1'b0, dvs_q});
    diff    = partial[XLEN-1:0] - dvs_q;
    last    = step && (cnt_q == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remainder <= '0;
      quotient  <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
    end else if (start) begin
      remainder <= '0;
      quotient  <= dividend;
      dvs_q     <= divisor;
      cnt_q     <= '0;
    end else if (step) begin
      remainder <= take ? diff : partial[XLEN-1:0];
      quotient  <= {quotient[XLEN-2:0], take};
      cnt_q     <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M EX unit: MUL stalls 2 cycles, divide 34 (1 for div-by-zero / overflow).
// BUSYWAIT freezes the pipeline until the one-cycle DONE; FLUSH aborts at once.
module ex_muldiv_unit #(
  parameter int XLEN  = ex_muldiv_unit_pkg::MD_XLEN,
  parameter int CNT_W = ex_muldiv_unit_pkg::MD_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  ex_muldiv_unit_if.slave  bus
);
  import ex_muldiv_unit_pkg::*;

  state_t          state;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q, result_q;
  logic            done_q, q_neg_q, r_neg_q;

  logic [2:0]      f3_in;
  logic            is_m, accept, sgn_div, a_neg, b_neg;
  logic            div_zero, div_ovf, div_start, div_step, div_last;
  logic [XLEN-1:0] a_mag, b_mag, special_res;
  logic [XLEN-1:0] quo, rem, q_fix, r_fix, fix_res, mul_res;
  logic [2*XLEN-1:0] a_ext, b_ext, prod;

  always_comb begin
    f3_in     = bus.IN_ALU_OP[2:0];
    is_m      = is_m_op(bus.IN_ALU_OP);
    accept    = (state == ST_IDLE) && is_m && !bus.IN_FLUSH;
    sgn_div   = !f3_in[0];
    a_neg     = sgn_div && bus.IN_DATA1[XLEN-1];
    b_neg     = sgn_div && bus.IN_DATA2[XLEN-1];
    a_mag     = a_neg ? (XLEN'(0) - bus.IN_DATA1) : bus.IN_DATA1;
    b_mag     = b_neg ? (XLEN'(0) - bus.IN_DATA2) : bus.IN_DATA2;
    div_zero  = (bus.IN_DATA2 == '0);
    div_ovf   = sgn_div && (bus.IN_DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.IN_DATA2 == '1);
    // Overflow quotient equals the dividend itself (most negative value).
    if (div_zero)
      special_res = f3_in[1] ? bus.IN_DATA1 : '1;
    else
      special_res = f3_in[1] ? '0 : bus.IN_DATA1;
    div_start = accept && f3_in[2] && !div_zero && !div_ovf;
    div_step  = (state == ST_DIV);
  end

  // Sign-extend to 2*XLEN so one unsigned multiply covers all four signedness cases.
  always_comb begin
    a_ext   = {{XLEN{((f3_q == F3_MULH) || (f3_q == F3_MULHSU)) && a_q[XLEN-1]}}, a_q};
    b_ext   = {{XLEN{(f3_q == F3_MULH) && b_q[XLEN-1]}}, b_q};
    prod    = a_ext * b_ext;
    mul_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    q_fix   = q_neg_q ? (XLEN'(0) - quo) : quo;
    r_fix   = r_neg_q ? (XLEN'(0) - rem) : rem;
    fix_res = f3_q[1] ? r_fix : q_fix;
  end

  div_core #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_div_core (
    .clk       (CLK),
    .rst_n     (RESET),
    .start     (div_start),
    .step      (div_step),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem),
    .last      (div_last)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else if (bus.IN_FLUSH) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (is_m) begin
            f3_q    <= f3_in;
            a_q     <= bus.IN_DATA1;
            b_q     <= bus.IN_DATA2;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            if (!f3_in[2]) begin
              state <= ST_MUL;
            end else if (div_zero || div_ovf) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          result_q <= mul_res;
          done_q   <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DIV: begin
          if (div_last) state <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.OUT_RESULT   = result_q;
  assign bus.OUT_DONE     = done_q;
  assign bus.OUT_BUSYWAIT = RESET && !bus.IN_FLUSH &&
                            (((state == ST_IDLE) && is_m) || (state == ST_MUL) ||
                             (state == ST_DIV) || (state == ST_FIX));

endmodule
